dcmi_ram_wbuf: RTL and testbench

DCMI_RAM_WBUF -- requirements
Module: dcmi_ram_wbuf

---
 rtl/dcmi_ram_wbuf.sv | 97 +++++++++
 tb/tb_dcmi_ram_wbuf.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcmi_ram_wbuf.sv
// DCMI-to-SRAM write buffer: accepts DCMI word writes into a small FIFO
// and drains them to SRAM through a req/gnt handshake.
module dcmi_ram_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 22
) (
    input  logic                     hclk,
    input  logic                     rst,
    input  logic                     wbuf_en,
    input  logic                     err_clr,
    input  logic                     ram_wr_req,
    output logic                     ram_wr_ack,
    input  logic [23:0]              ram_waddr,
    input  logic [31:0]              ram_wdata,
    output logic                     sram_req,
    input  logic                     sram_gnt,
    output logic [AW-1:0]            sram_addr,
    output logic [31:0]              sram_wdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     wbuf_empty,
    output logic                     err_misalign,
    output logic [15:0]              wr_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] word_addr;
    logic          accept;
    logic          aligned;
    logic          push;
    logic          pop;

    // Byte address to word address, zero-extended or truncated to AW.
    for (genvar i = 0; i < AW; i++) begin : g_wa
        if (i < 22) begin : g_in
            assign word_addr[i] = ram_waddr[i+2];
        end else begin : g_zero
            assign word_addr[i] = 1'b0;
        end
    end

    // The registered ack blocks back-to-back accepts of a held request.
    assign accept  = ram_wr_req & ~ram_wr_ack & wbuf_en & (fifo_level < FULL);
    assign aligned = (ram_waddr[1:0] == 2'b00);
    assign push    = accept & aligned;
    assign pop     = sram_req & sram_gnt;

    assign sram_req   = (fifo_level != '0);
    assign sram_addr  = addr_mem[rd_ptr];
    assign sram_wdata = data_mem[rd_ptr];
    assign wbuf_empty = (fifo_level == '0) & ~ram_wr_ack;

    always_ff @(posedge hclk) begin
        if (rst) begin
            ram_wr_ack   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            err_misalign <= 1'b0;
            wr_cnt       <= '0;
        end else begin
            ram_wr_ack <= accept;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                wr_cnt <= wr_cnt + 16'd1;
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (accept && !aligned) begin
                err_misalign <= 1'b1;
            end else if (err_clr) begin
                err_misalign <= 1'b0;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge hclk) begin
        if (push && !rst) begin
            addr_mem[wr_ptr] <= word_addr;
            data_mem[wr_ptr] <= ram_wdata;
        end
    end

endmodule

// File: tb/tb_dcmi_ram_wbuf.sv
// Self-checking bench for dcmi_ram_wbuf: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dcmi_ram_wbuf;

    localparam int DEPTH = 4;
    localparam int AW    = 22;

    logic          hclk = 1'b0;
    logic          rst = 1'b1;
    logic          wbuf_en = 1'b1;
    logic          err_clr = 1'b0;
    logic          ram_wr_req = 1'b0;
    logic          ram_wr_ack;
    logic [23:0]   ram_waddr = '0;
    logic [31:0]   ram_wdata = '0;
    logic          sram_req;
    logic          sram_gnt = 1'b0;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [2:0]    fifo_level;
    logic          wbuf_empty;
    logic          err_misalign;
    logic [15:0]   wr_cnt;

    int nvec = 0;
    int nmis = 0;

    // Reference model: queue of {word address, data}
    logic [53:0] m_q[$];
    logic        m_ack = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [53:0] wlog[$];

    dcmi_ram_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .hclk(hclk), .rst(rst), .wbuf_en(wbuf_en), .err_clr(err_clr),
        .ram_wr_req(ram_wr_req), .ram_wr_ack(ram_wr_ack),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .sram_req(sram_req), .sram_gnt(sram_gnt),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .fifo_level(fifo_level), .wbuf_empty(wbuf_empty),
        .err_misalign(err_misalign), .wr_cnt(wr_cnt)
    );

    always #5 hclk = ~hclk;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time expired, want finish");
        $fatal(1);
    end

    // Advance one clock; the model steps on the inputs applied for this edge.
    task automatic tick();
        bit acc;
        if (sram_req && sram_gnt) wlog.push_back({sram_addr, sram_wdata});
        if (rst) begin
            m_q.delete();
            m_ack = 1'b0;
            m_err = 1'b0;
            m_cnt = '0;
        end else begin
            acc = ram_wr_req && !m_ack && wbuf_en && (m_q.size() < DEPTH);
            if (m_q.size() != 0 && sram_gnt) begin
                void'(m_q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (acc && ram_waddr[1:0] == 2'b00)
                m_q.push_back({ram_waddr[23:2], ram_wdata});
            if (acc && ram_waddr[1:0] != 2'b00) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_ack = acc;
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic put(input logic [23:0] a, input logic [31:0] d);
        ram_waddr  = a;
        ram_wdata  = d;
        ram_wr_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ram_wr_ack) break;
        end
        nvec++;
        if (ram_wr_ack !== 1'b1) begin
            nmis++;
            $display("FAIL put_ack: got %b want 1 (addr %h)", ram_wr_ack, a);
        end
        ram_wr_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        nvec++; if (ram_wr_ack !== 1'b0) begin nmis++; $display("FAIL rst_ack: got %b want 0", ram_wr_ack); end
        nvec++; if (sram_req !== 1'b0) begin nmis++; $display("FAIL rst_sram_req: got %b want 0", sram_req); end
        nvec++; if (fifo_level !== 3'd0) begin nmis++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        nvec++; if (wbuf_empty !== 1'b1) begin nmis++; $display("FAIL rst_empty: got %b want 1", wbuf_empty); end
        nvec++; if (err_misalign !== 1'b0) begin nmis++; $display("FAIL rst_err: got %b want 0", err_misalign); end
        nvec++; if (wr_cnt !== 16'd0) begin nmis++; $display("FAIL rst_cnt: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_single();
        sram_gnt   = 1'b1;
        ram_waddr  = 24'h000104;
        ram_wdata  = 32'hA5A5_0001;
        ram_wr_req = 1'b1;
        tick();
        nvec++; if (ram_wr_ack !== 1'b1) begin nmis++; $display("FAIL single_ack: got %b want 1", ram_wr_ack); end
        nvec++; if (sram_req !== 1'b1) begin nmis++; $display("FAIL single_req: got %b want 1", sram_req); end
        nvec++; if (sram_addr !== 22'h41) begin nmis++; $display("FAIL single_addr: got %h want 41", sram_addr); end
        nvec++; if (sram_wdata !== 32'hA5A5_0001) begin nmis++; $display("FAIL single_data: got %h want a5a50001", sram_wdata); end
        ram_wr_req = 1'b0;
        tick();
        nvec++; if (ram_wr_ack !== 1'b0) begin nmis++; $display("FAIL single_ack_off: got %b want 0", ram_wr_ack); end
        nvec++; if (wr_cnt !== 16'd1) begin nmis++; $display("FAIL single_cnt: got %0d want 1", wr_cnt); end
        nvec++; if (wbuf_empty !== 1'b1) begin nmis++; $display("FAIL single_empty: got %b want 1", wbuf_empty); end
    endtask

    task automatic test_fill();
        logic [53:0] e[5];
        logic [31:0] r;
        int idx = 0;
        wlog.delete();
        sram_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            e[i] = {22'h80 + 22'(i), r};
        end
        for (int c = 0; c < 14; c++) begin
            ram_wr_req = (idx < 5);
            ram_waddr  = {e[idx < 5 ? idx : 4][53:32], 2'b00};
            ram_wdata  = e[idx < 5 ? idx : 4][31:0];
            tick();
            if (ram_wr_ack) idx++;
        end
        nvec++; if (idx != 4) begin nmis++; $display("FAIL fill_acks: got %0d want 4", idx); end
        nvec++; if (fifo_level !== 3'd4) begin nmis++; $display("FAIL fill_level: got %0d want 4", fifo_level); end
        nvec++; if (ram_wr_ack !== 1'b0) begin nmis++; $display("FAIL fill_held: got %b want 0", ram_wr_ack); end
        nvec++; if (sram_addr !== e[0][53:32]) begin nmis++; $display("FAIL fill_head: got %h want %h", sram_addr, e[0][53:32]); end
        sram_gnt = 1'b1;
        for (int c = 0; c < 40; c++) begin
            ram_wr_req = (idx < 5);
            ram_waddr  = {e[idx < 5 ? idx : 4][53:32], 2'b00};
            ram_wdata  = e[idx < 5 ? idx : 4][31:0];
            tick();
            if (ram_wr_ack) idx++;
            if (idx == 5 && !ram_wr_req && fifo_level == 3'd0) break;
        end
        ram_wr_req = 1'b0;
        nvec++; if (idx != 5) begin nmis++; $display("FAIL fill_acks5: got %0d want 5", idx); end
        nvec++; if (wlog.size() != 5) begin nmis++; $display("FAIL fill_writes: got %0d want 5", wlog.size()); end
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            nvec++;
            if (wlog[i] !== e[i]) begin nmis++; $display("FAIL fill_order%0d: got %h want %h", i, wlog[i], e[i]); end
        end
        nvec++; if (wr_cnt !== 16'd6) begin nmis++; $display("FAIL fill_cnt: got %0d want 6", wr_cnt); end
    endtask

    task automatic test_misalign();
        sram_gnt = 1'b1;
        put(24'h000102, 32'h1234_5678);
        nvec++; if (sram_req !== 1'b0) begin nmis++; $display("FAIL mis_req: got %b want 0", sram_req); end
        nvec++; if (err_misalign !== 1'b1) begin nmis++; $display("FAIL mis_err: got %b want 1", err_misalign); end
        tick();
        nvec++; if (err_misalign !== 1'b1) begin nmis++; $display("FAIL mis_sticky: got %b want 1", err_misalign); end
        nvec++; if (fifo_level !== 3'd0) begin nmis++; $display("FAIL mis_level: got %0d want 0", fifo_level); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        nvec++; if (err_misalign !== 1'b0) begin nmis++; $display("FAIL mis_clr: got %b want 0", err_misalign); end
        ram_waddr  = 24'h000103;
        ram_wr_req = 1'b1;
        err_clr    = 1'b1;
        tick();
        err_clr    = 1'b0;
        ram_wr_req = 1'b0;
        nvec++; if (ram_wr_ack !== 1'b1) begin nmis++; $display("FAIL mis_ack2: got %b want 1", ram_wr_ack); end
        nvec++; if (err_misalign !== 1'b1) begin nmis++; $display("FAIL mis_setwins: got %b want 1", err_misalign); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        nvec++; if (err_misalign !== 1'b0) begin nmis++; $display("FAIL mis_clr2: got %b want 0", err_misalign); end
    endtask

    task automatic test_push_pop();
        logic [53:0] e[3];
        e[0] = {22'h3001, 32'hAAAA_0000};
        e[1] = {22'h3002, 32'hBBBB_1111};
        e[2] = {22'h3003, 32'hCCCC_2222};
        wlog.delete();
        sram_gnt = 1'b0;
        put({e[0][53:32], 2'b00}, e[0][31:0]);
        put({e[1][53:32], 2'b00}, e[1][31:0]);
        tick();
        nvec++; if (fifo_level !== 3'd2) begin nmis++; $display("FAIL pp_pre: got %0d want 2", fifo_level); end
        ram_waddr  = {e[2][53:32], 2'b00};
        ram_wdata  = e[2][31:0];
        ram_wr_req = 1'b1;
        sram_gnt   = 1'b1;
        tick();
        ram_wr_req = 1'b0;
        nvec++; if (ram_wr_ack !== 1'b1) begin nmis++; $display("FAIL pp_ack: got %b want 1", ram_wr_ack); end
        nvec++; if (fifo_level !== 3'd2) begin nmis++; $display("FAIL pp_level: got %0d want 2", fifo_level); end
        nvec++; if (sram_addr !== e[1][53:32]) begin nmis++; $display("FAIL pp_head: got %h want %h", sram_addr, e[1][53:32]); end
        for (int c = 0; c < 10 && fifo_level != 3'd0; c++) tick();
        nvec++; if (wlog.size() != 3) begin nmis++; $display("FAIL pp_writes: got %0d want 3", wlog.size()); end
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            nvec++;
            if (wlog[i] !== e[i]) begin nmis++; $display("FAIL pp_order%0d: got %h want %h", i, wlog[i], e[i]); end
        end
    endtask

    task automatic test_wbuf_en();
        logic [15:0] cnt0;
        sram_gnt = 1'b0;
        put(24'h000400, 32'h0000_0400);
        put(24'h000404, 32'h0000_0404);
        tick();
        cnt0 = m_cnt;
        wbuf_en    = 1'b0;
        ram_waddr  = 24'h000408;
        ram_wdata  = 32'h0000_0408;
        ram_wr_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            nvec++; if (ram_wr_ack !== 1'b0) begin nmis++; $display("FAIL en_noack%0d: got %b want 0", c, ram_wr_ack); end
        end
        nvec++; if (fifo_level !== 3'd2) begin nmis++; $display("FAIL en_level: got %0d want 2", fifo_level); end
        sram_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            nvec++; if (ram_wr_ack !== 1'b0) begin nmis++; $display("FAIL en_drain_ack%0d: got %b want 0", c, ram_wr_ack); end
        end
        nvec++; if (fifo_level !== 3'd0) begin nmis++; $display("FAIL en_drained: got %0d want 0", fifo_level); end
        nvec++; if (wr_cnt !== cnt0 + 16'd2) begin nmis++; $display("FAIL en_cnt: got %0d want %0d", wr_cnt, cnt0 + 16'd2); end
        wbuf_en = 1'b1;
        tick();
        ram_wr_req = 1'b0;
        nvec++; if (ram_wr_ack !== 1'b1) begin nmis++; $display("FAIL en_resume: got %b want 1", ram_wr_ack); end
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_reset_mid();
        sram_gnt = 1'b0;
        put(24'h000501, 32'hDEAD_0001);
        put(24'h000500, 32'h0000_0500);
        put(24'h000504, 32'h0000_0504);
        put(24'h000508, 32'h0000_0508);
        tick();
        nvec++; if (fifo_level !== 3'd3) begin nmis++; $display("FAIL rm_pre: got %0d want 3", fifo_level); end
        ram_waddr  = 24'h00050C;
        ram_wr_req = 1'b1;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        ram_wr_req = 1'b0;
        nvec++; if (ram_wr_ack !== 1'b0) begin nmis++; $display("FAIL rm_ack: got %b want 0", ram_wr_ack); end
        nvec++; if (sram_req !== 1'b0) begin nmis++; $display("FAIL rm_req: got %b want 0", sram_req); end
        nvec++; if (fifo_level !== 3'd0) begin nmis++; $display("FAIL rm_level: got %0d want 0", fifo_level); end
        nvec++; if (wr_cnt !== 16'd0) begin nmis++; $display("FAIL rm_cnt: got %0d want 0", wr_cnt); end
        nvec++; if (wbuf_empty !== 1'b1) begin nmis++; $display("FAIL rm_empty: got %b want 1", wbuf_empty); end
        nvec++; if (err_misalign !== 1'b0) begin nmis++; $display("FAIL rm_err: got %b want 0", err_misalign); end
        tick();
        nvec++; if (ram_wr_ack !== 1'b0) begin nmis++; $display("FAIL rm_ack_after: got %b want 0", ram_wr_ack); end
        nvec++; if (sram_req !== 1'b0) begin nmis++; $display("FAIL rm_req_after: got %b want 0", sram_req); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            wbuf_en  = ($urandom_range(0, 9) != 0);
            sram_gnt = $urandom_range(0, 1) == 1;
            err_clr  = ($urandom_range(0, 15) == 0);
            if (!ram_wr_req && $urandom_range(0, 9) < 6) begin
                r = $urandom;
                ram_waddr = r[23:0];
                if ($urandom_range(0, 7) != 0) ram_waddr[1:0] = 2'b00;
                ram_wdata  = $urandom;
                ram_wr_req = 1'b1;
            end
            tick();
            if (ram_wr_ack || rst) ram_wr_req = 1'b0;
            nvec++; if (ram_wr_ack !== m_ack) begin nmis++; $display("FAIL rnd_ack @%0d: got %b want %b", n, ram_wr_ack, m_ack); end
            nvec++; if (32'(fifo_level) != m_q.size()) begin nmis++; $display("FAIL rnd_level @%0d: got %0d want %0d", n, fifo_level, m_q.size()); end
            nvec++; if (sram_req !== (m_q.size() != 0)) begin nmis++; $display("FAIL rnd_req @%0d: got %b want %b", n, sram_req, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                nvec++;
                if ({sram_addr, sram_wdata} !== m_q[0]) begin
                    nmis++;
                    $display("FAIL rnd_head @%0d: got %h want %h", n, {sram_addr, sram_wdata}, m_q[0]);
                end
            end
            nvec++; if (err_misalign !== m_err) begin nmis++; $display("FAIL rnd_err @%0d: got %b want %b", n, err_misalign, m_err); end
            nvec++; if (wr_cnt !== m_cnt) begin nmis++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, wr_cnt, m_cnt); end
            nvec++;
            if (wbuf_empty !== (m_q.size() == 0 && !m_ack)) begin
                nmis++;
                $display("FAIL rnd_empty @%0d: got %b want %b", n, wbuf_empty, m_q.size() == 0 && !m_ack);
            end
        end
        rst      = 1'b0;
        err_clr  = 1'b0;
        wbuf_en  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_misalign();
        test_push_pop();
        test_wbuf_en();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
